// File: rtl/ring_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ring_decoder
// Purpose  : Encodes a one-hot ring phase, checks each step is a legal
//            rotation, counts laps and flags illegal codes/steps.
//            Optional bidirectional stepping via RING_DEC_BIDIR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ring_decoder #(
    parameter int N     = 4,
    parameter int IDX_W = 2,
    parameter int LAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     ring_in,
    input  logic             clr_err,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             err,
    output logic             err_pulse,
    output logic [7:0]       err_cnt
`ifdef RING_DEC_BIDIR_EN
    ,
    output logic             dir
`endif
);

    typedef enum logic [1:0] {
        S_ACQ   = 2'd0,
        S_TRACK = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
    logic             err_q, err_d;
    logic             err_pulse_q, err_pulse_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
`ifdef RING_DEC_BIDIR_EN
    logic             dir_q, dir_d;
    logic [IDX_W-1:0] prv;
`endif

    logic             one_hot;
    logic [IDX_W-1:0] enc;
    logic [IDX_W-1:0] nxt;
    logic             err_hit;

    // Clearing the lowest set bit leaves zero only for a single-bit word.
    assign one_hot = (ring_in != '0) && ((ring_in & (ring_in - ONE_HOT0)) == '0);

    always_comb begin
        enc = '0;
        for (int i = 0; i < N; i++) begin
            if (ring_in[i]) begin
                enc = IDX_W'(i);
            end
        end
    end

    assign nxt = (idx_q == '0) ? IDX_W'(N - 1) : idx_q - IDX_W'(1);
`ifdef RING_DEC_BIDIR_EN
    assign prv = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lap_cnt_d   = lap_cnt_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        err_hit     = 1'b0;
`ifdef RING_DEC_BIDIR_EN
        dir_d       = dir_q;
`endif

        if (clr_err) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end

        if (en) begin
            case (state_q)
                S_ACQ, S_ERR: begin
                    if (one_hot) begin
                        idx_d   = enc;
                        state_d = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (ring_in == (ONE_HOT0 << idx_q)) begin
                        idx_d = idx_q;
                    end else if (ring_in == (ONE_HOT0 << nxt)) begin
                        idx_d = nxt;
                        if (idx_q == '0) begin
                            lap_cnt_d = lap_cnt_q + LAP_W'(1);
                        end
`ifdef RING_DEC_BIDIR_EN
                        dir_d = 1'b0;
                    end else if (ring_in == (ONE_HOT0 << prv)) begin
                        idx_d = prv;
                        dir_d = 1'b1;
                        if (idx_q == IDX_W'(N - 1)) begin
                            lap_cnt_d = lap_cnt_q + LAP_W'(1);
                        end
`endif
                    end else begin
                        state_d = S_ERR;
                        err_hit = 1'b1;
                    end
                end
                default: state_d = S_ACQ;
            endcase
        end

        // A fresh error outranks a simultaneous clear.
        if (err_hit) begin
            err_pulse_d = 1'b1;
            err_d       = 1'b1;
            if (clr_err) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACQ;
            idx_q       <= '0;
            lap_cnt_q   <= '0;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lap_cnt_q   <= lap_cnt_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef RING_DEC_BIDIR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign dir = dir_q;
`endif

    assign idx       = idx_q;
    assign valid     = (state_q == S_TRACK);
    assign lap_cnt   = lap_cnt_q;
    assign err       = err_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_decoder
// Purpose  : Directed self-checking bench for ring_decoder (N=4, LAP_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] ring_in = 4'b0000;
    logic       clr_err = 1'b0;
    logic [1:0] idx;
    logic       valid;
    logic [7:0] lap_cnt;
    logic       err;
    logic       err_pulse;
    logic [7:0] err_cnt;
`ifdef RING_DEC_BIDIR_EN
    logic       dir;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ring_decoder #(.N(4), .IDX_W(2), .LAP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ring_in   (ring_in),
        .clr_err   (clr_err),
        .idx       (idx),
        .valid     (valid),
        .lap_cnt   (lap_cnt),
        .err       (err),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
`ifdef RING_DEC_BIDIR_EN
        ,
        .dir       (dir)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic e, input logic [3:0] r, input logic c);
        en      = e;
        ring_in = r;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 1'b0;
        ring_in = 4'b0000;
        clr_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [3:0] rot_in  [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
    logic [1:0] rot_idx [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};

    initial begin
        // Reset values
        do_reset();
        check("rst_idx",   32'(idx), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_lap",   32'(lap_cnt), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_pulse", 32'(err_pulse), 32'd0);
        check("rst_cnt",   32'(err_cnt), 32'd0);

        // Illegal code while acquiring is ignored
        step(1'b1, 4'b0000, 1'b0);
        check("acq_zero_valid", 32'(valid), 32'd0);
        check("acq_zero_err",   32'(err), 32'd0);

        // Forward rotation with wrap
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, rot_in[i], 1'b0);
            check("rot_valid", 32'(valid), 32'd1);
            check("rot_idx",   32'(idx), 32'(rot_idx[i]));
            if (i == 3) check("rot_lap_before_wrap", 32'(lap_cnt), 32'd0);
        end
        check("rot_lap", 32'(lap_cnt), 32'd1);
        check("rot_err", 32'(err), 32'd0);

        // Two-hot code raises an error; resync does not count a lap
        do_reset();
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b1100, 1'b0);
        check("twohot_pulse", 32'(err_pulse), 32'd1);
        check("twohot_err",   32'(err), 32'd1);
        check("twohot_cnt",   32'(err_cnt), 32'd1);
        check("twohot_valid", 32'(valid), 32'd0);
        check("twohot_idx",   32'(idx), 32'd2);
        step(1'b1, 4'b0010, 1'b0);
        check("resync_pulse", 32'(err_pulse), 32'd0);
        check("resync_valid", 32'(valid), 32'd1);
        check("resync_idx",   32'(idx), 32'd1);
        check("resync_lap",   32'(lap_cnt), 32'd0);
        check("resync_err",   32'(err), 32'd1);

        // Resync from idx 0 to idx 3 must not count a lap
        do_reset();
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        check("resync_wrap_idx", 32'(idx), 32'd3);
        check("resync_wrap_lap", 32'(lap_cnt), 32'd0);

        // en=0 masks illegal input
        do_reset();
        step(1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 1'b0);
        check("hold_idx",   32'(idx), 32'd2);
        check("hold_err",   32'(err), 32'd0);
        check("hold_valid", 32'(valid), 32'd1);
        step(1'b1, 4'b0000, 1'b0);
        check("zero_cnt", 32'(err_cnt), 32'd1);
        check("zero_err", 32'(err), 32'd1);

        // Lap counter wraps after 256 revolutions
        do_reset();
        step(1'b1, 4'b1000, 1'b0);
        for (int r = 1; r <= 257; r++) begin
            step(1'b1, 4'b0100, 1'b0);
            step(1'b1, 4'b0010, 1'b0);
            step(1'b1, 4'b0001, 1'b0);
            step(1'b1, 4'b1000, 1'b0);
            if (r == 255) check("lap_255", 32'(lap_cnt), 32'd255);
            if (r == 256) check("lap_256", 32'(lap_cnt), 32'd0);
        end
        check("lap_257",     32'(lap_cnt), 32'd1);
        check("lap_err",     32'(err), 32'd0);
        check("lap_err_cnt", 32'(err_cnt), 32'd0);

        // Error on the same cycle as clr_err wins; clr_err alone clears
        do_reset();
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0001, 1'b1);
        check("clrhit_err",   32'(err), 32'd1);
        check("clrhit_cnt",   32'(err_cnt), 32'd1);
        check("clrhit_pulse", 32'(err_pulse), 32'd1);
        step(1'b0, 4'b0001, 1'b1);
        check("clr_err",   32'(err), 32'd0);
        check("clr_cnt",   32'(err_cnt), 32'd0);
        check("clr_pulse", 32'(err_pulse), 32'd0);
        check("clr_valid", 32'(valid), 32'd0);
        check("clr_idx",   32'(idx), 32'd2);

        // err_cnt saturates at 255
        do_reset();
        step(1'b1, 4'b1000, 1'b0);
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 4'b0000, 1'b0);
            step(1'b1, 4'b1000, 1'b0);
        end
        check("sat_cnt", 32'(err_cnt), 32'd255);
        check("sat_err", 32'(err), 32'd1);

        // Reverse step: legal only with the bidirectional option
        do_reset();
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
`ifdef RING_DEC_BIDIR_EN
        check("rev_dir",   32'(dir), 32'd1);
        check("rev_idx",   32'(idx), 32'd1);
        check("rev_err",   32'(err), 32'd0);
        check("rev_valid", 32'(valid), 32'd1);
        step(1'b1, 4'b0001, 1'b0);
        check("fwd_dir", 32'(dir), 32'd0);
        check("fwd_idx", 32'(idx), 32'd0);
`else
        check("rev_err",   32'(err), 32'd1);
        check("rev_pulse", 32'(err_pulse), 32'd1);
        check("rev_valid", 32'(valid), 32'd0);
        check("rev_idx",   32'(idx), 32'd0);
`endif

        // Reset mid-error clears everything
        step(1'b1, 4'b1111, 1'b0);
        do_reset();
        check("rst2_err",   32'(err), 32'd0);
        check("rst2_cnt",   32'(err_cnt), 32'd0);
        check("rst2_valid", 32'(valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ring_decoder.md
Name: ring_decoder

Overview:
- Receiver-side companion to the one-hot ring counter.
- Samples a one-hot ring phase word and encodes it to a binary index.
- Checks that every step is a legal rotation, counts full revolutions (laps), and flags illegal codes or illegal steps.
- Sits downstream of a ring-counter phase generator; used for phase reporting and fault monitoring.

Parameters:
- N, default 4: ring width in bits; must be at least 2.
- IDX_W, default 2: index width, equal to $clog2(N).
- LAP_W, default 8: lap counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high; clears all state on a rising clk edge while high.
- en  input  1  sample enable; ring_in is evaluated only in cycles where en=1.
- ring_in  input  N  one-hot phase word from the ring counter.
- clr_err  input  1  clears the sticky err flag and err_cnt.
- idx  output  IDX_W  binary index of the last accepted one-hot phase.
- valid  output  1  high while in TRACK state.
- lap_cnt  output  LAP_W  completed revolutions; wraps modulo 2^LAP_W.
- err  output  1  sticky error flag.
- err_pulse  output  1  one-cycle pulse on each detected error.
- err_cnt  output  8  errors since the last clear; saturates at 255.

Behaviour:
- Reset values: idx=0, valid=0, lap_cnt=0, err=0, err_pulse=0, err_cnt=0, state=ACQ.
- Legal rotation direction is high-to-low: the bit moves from index k to index k-1. Index 0 wraps to index N-1. Example for N=4: 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- Definitions:
  - "one-hot" means exactly one bit of ring_in is set.
  - nxt = (idx==0) ? N-1 : idx-1.
- All outputs are registered. A sample accepted in cycle t is reflected on the outputs in cycle t+1 (1-cycle latency).
- State ACQ (valid=0):
  - en=1 and one-hot: idx<=encoded index; go to TRACK.
  - en=1 and not one-hot: stay in ACQ; no error is raised.
- State TRACK (valid=1), when en=1:
  - ring_in == one-hot(idx): hold; no change.
  - ring_in == one-hot(nxt): idx<=nxt. If idx was 0 (wrap to N-1), lap_cnt increments.
  - Otherwise: go to ERR. Raise err_pulse and set err. err_cnt increments unless saturated. idx and lap_cnt hold.
- TRACK with en=0: no change.
- State ERR (valid=0):
  - en=1 and one-hot: resync. idx<=encoded index; go to TRACK; lap_cnt is not incremented.
  - en=1 and not one-hot: stay in ERR; no additional error counted.
- err and err_cnt:
  - err stays set until clr_err=1 or rst=1.
  - clr_err does not change state, idx, or lap_cnt.
- Simultaneous events:
  - If clr_err=1 in the same cycle an error is detected, the error wins: err=1, err_cnt=1, err_pulse=1.
  - rst overrides everything, including during an error or mid-revolution.
- Illegal codes include all-zero and any code with two or more bits set. In TRACK they count as errors.
- lap_cnt wraps from 2^LAP_W-1 to 0 without raising an error.

Optional Feature:
- Macro RING_DEC_BIDIR_EN.
- Defined:
  - An extra output port dir (1 bit, reset 0) is present.
  - A step to prv = (idx==N-1) ? 0 : idx+1 is legal in TRACK. It sets dir=1, and lap_cnt increments on the wrap from N-1 to 0.
  - A forward (nxt) step sets dir=0.
  - Hold leaves dir unchanged.
- Not defined: the dir port is absent, and a step to prv is an error, exactly like any other illegal step.

Test Plan:
- Reset, then en=1 with ring_in 1000,0100,0010,0001,1000,0100 on consecutive cycles -> valid=1 from cycle 2; idx 3,2,1,0,3,2; lap_cnt=1 after the 0->3 wrap; err=0.
- Lock on 0100, then apply 1100 -> err_pulse for one cycle, err=1, err_cnt=1, valid=0. Then apply 0010 -> valid=1, idx=1, lap_cnt unchanged.
- In TRACK at idx=2, hold en=0 while ring_in=0000 for 5 cycles -> no error, idx=2. Then en=1 with ring_in=0000 -> err_cnt=1.
- Run 256 revolutions with LAP_W=8 -> lap_cnt reads 0 after 256 laps, 1 after 257; no error.
- Raise clr_err in the same cycle as an illegal step 0100 -> 0001 -> err=1, err_cnt=1. Then clr_err alone -> err=0, err_cnt=0, state unchanged.
- With RING_DEC_BIDIR_EN, lock on 0001, then apply 0010 -> dir=1, idx=1, no error. Without the macro, the same stimulus -> err=1.
